instr_feeder: RTL and testbench
===============================

INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 clk  in  1  system clock, all state on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 start  in  1  begin program execution from IDLE or HALT.
REQ-004 done  in  1  processor Done pulse, one cycle at instruction completion.
REQ-005 rom_addr  out  5  program ROM word address.
REQ-006 rom_data  in  9  ROM word, valid the cycle after rom_addr is presented.
REQ-007 din  out  9  processor DIN: instruction word {op[8:6], RX[5:3], RY[2:0]} or mvi immediate.
REQ-008 run  out  1  processor run.
REQ-009 pc  out  5  current program counter.
REQ-010 busy  out  1  high in every state except IDLE and HALT.
REQ-011 halted  out  1  high in HALT.
REQ-012 err  out  1  sticky error flag, cleared on start or rst.

Function
REQ-013 States: IDLE, RD, ISSUE_A, ISSUE_B, IMM_RD, IMM, WAIT, HALT. rom_addr = pc in all states.
REQ-014 IDLE: run=0, din=0. On start: pc<=0, go RD.
REQ-015 RD: one cycle for ROM latency. The next state is ISSUE_A. The word is captured into an internal instr register at the RD->ISSUE_A edge.
REQ-016 In ISSUE_A, decode instr.
- Opcodes 000-011: din=instr, run=0, go ISSUE_B.
- Opcode 111 (HALT): go HALT; nothing is issued.
- Opcodes 100-110: set err, go HALT.
REQ-017 ISSUE_B: din=instr, run=1 for exactly one cycle.
- If op=001 (mvi): pc<=pc+1, go IMM_RD.
- Otherwise: go WAIT.
REQ-018 IMM_RD: run=0, din=instr. The immediate is captured from rom_data at exit, then go IMM.
REQ-019 IMM: din=immediate, run=0. Hold until done=1, then pc<=pc+1, go RD.
REQ-020 WAIT: din=instr, run=0. Hold until done=1, then pc<=pc+1, go RD.
REQ-021 din is stable for at least two consecutive cycles before and during the run=1 cycle. This guarantees the processor's IR holds the new word when run is sampled.
REQ-022 run is never high outside ISSUE_B.
REQ-023 pc is 5-bit and wraps 31->0. An mvi at address 31 takes its immediate from address 0.
REQ-024 done asserted in any state other than WAIT or IMM is ignored.
REQ-025 HALT: run=0, din=0, halted=1. start restarts at pc=0 and clears err.
REQ-026 start while busy is ignored.

Reset
REQ-027 rst forces state=IDLE, pc=0, instr=0, immediate=0, err=0, din=0, run=0, busy=0, halted=0, from any state including mid-instruction.

Configuration
REQ-028 Macro FEEDER_WATCHDOG_EN enables a done timeout.
- With the macro: if WAIT or IMM lasts 16 cycles without done, set err and go HALT.
- Without the macro: WAIT and IMM wait indefinitely; err is set only by illegal opcodes.

Structure
REQ-029 Package feeder_pkg holds:
- opcode constants OP_MV=3'b000, OP_MVI=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_HALT=3'b111;
- the state enum type;
- the watchdog limit constant WDOG_LIMIT=16.
REQ-030 The watchdog counter is sub-module feeder_wdog (clear/enable in, expire out). It is instantiated only under FEEDER_WATCHDOG_EN.

Verification
REQ-031 ROM[0]=9'b000_001_010 (mv R1,R2), ROM[1]=9'b111_000_000.
- Stimulus: start; done pulses 2 cycles after run.
- Response: din=0x00A for two cycles, run high on the second, then halted=1 with pc=1.
REQ-032 ROM[0]=9'b001_011_000 (mvi R3), ROM[1]=9'h05A, ROM[2]=HALT.
- Response: din=0x058 then 0x05A from the cycle after IMM_RD until done; pc ends at 2.
REQ-033 ROM[0]=9'b010_000_001 (add), ROM[1]=9'b011_000_001 (sub), ROM[2]=HALT; done 4 cycles after each run.
- Response: exactly two run pulses, 0x081 then 0x0C1; halted with err=0.
REQ-034 ROM[0]=9'b100_000_000.
- Response: run never asserted; err=1, halted=1. A following start clears err.
REQ-035 Assert rst during WAIT of an add.
- Response: next cycle state=IDLE, pc=0, run=0, din=0. A later done pulse is ignored.
REQ-036 Watchdog and wrap.
- With FEEDER_WATCHDOG_EN and done withheld: err=1, halted=1 exactly 16 cycles after entering WAIT.
- Without the macro: still in WAIT after 100 cycles.
- ROM[31]=mvi, ROM[0]=0x033: rom_addr wraps 31->0 and din=0x033.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared types and constants for the instruction feeder: opcodes, FSM states, watchdog limit.
package feeder_pkg;

    localparam int unsigned DATA_W     = 9;
    localparam int unsigned ADDR_W     = 5;
    localparam int unsigned OP_W       = 3;
    localparam int unsigned WDOG_LIMIT = 16;
    localparam int unsigned WDOG_W     = $clog2(WDOG_LIMIT);

    localparam logic [OP_W-1:0] OP_MV   = 3'b000;
    localparam logic [OP_W-1:0] OP_MVI  = 3'b001;
    localparam logic [OP_W-1:0] OP_ADD  = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB  = 3'b011;
    localparam logic [OP_W-1:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        ISSUE_A,
        ISSUE_B,
        IMM_RD,
        IMM,
        WAIT,
        HALT
    } state_t;

    function automatic logic [OP_W-1:0] op_of(input logic [DATA_W-1:0] word);
        return word[DATA_W-1 -: OP_W];
    endfunction

    function automatic logic is_issuable(input logic [OP_W-1:0] op);
        return op inside {OP_MV, OP_MVI, OP_ADD, OP_SUB};
    endfunction

endpackage

// File: rtl/instr_feeder_if.sv
// Feeder buses: program ROM port and processor DIN/run/Done handshake.
interface instr_feeder_if;
    import feeder_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] din;
    logic              run;
    logic              done;

    modport master (
        output rom_addr, din, run,
        input  rom_data, done
    );

    modport slave (
        input  rom_addr, din, run,
        output rom_data, done
    );

endinterface

// File: rtl/feeder_wdog.sv
// Done-timeout counter: expire rises on the WDOG_LIMIT-th consecutive enabled cycle.
module feeder_wdog
    import feeder_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expire
);

    logic [WDOG_W-1:0] cnt;

    // expire is registered one count early so it is high during the last allowed cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (en) begin
            cnt    <= cnt + WDOG_W'(1);
            expire <= (cnt == WDOG_W'(WDOG_LIMIT - 2));
        end
    end

endmodule

// File: rtl/instr_feeder.sv
// Fetches program words from ROM and feeds them to the processor, one run pulse per instruction.
// Optional done-timeout watchdog enabled by defining FEEDER_WATCHDOG_EN.
module instr_feeder
    import feeder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_feeder_if.master    bus,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              run_q, run_d;
    logic              err_d, busy_d, halted_d;
    logic [OP_W-1:0]   op;
    logic              wdog_expire;

    assign op           = op_of(instr_q);
    assign bus.rom_addr = pc;
    assign bus.din      = din_q;
    assign bus.run      = run_q;

`ifdef FEEDER_WATCHDOG_EN
    logic in_wait;
    assign in_wait = (state_q == WAIT) || (state_q == IMM);

    feeder_wdog u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_wait),
        .en     (in_wait),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    // Next state plus next values of the registered outputs, decoded from the next state
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        instr_d = instr_q;
        imm_d   = imm_q;
        err_d   = err;

        unique case (state_q)
            IDLE, HALT: begin
                if (start) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = RD;
                end
            end
            RD: begin
                instr_d = bus.rom_data;
                state_d = ISSUE_A;
            end
            ISSUE_A: begin
                if (is_issuable(op)) begin
                    state_d = ISSUE_B;
                end else begin
                    err_d   = (op != OP_HALT);
                    state_d = HALT;
                end
            end
            ISSUE_B: begin
                if (op == OP_MVI) begin
                    pc_d    = pc + ADDR_W'(1);
                    state_d = IMM_RD;
                end else begin
                    state_d = WAIT;
                end
            end
            IMM_RD: begin
                imm_d   = bus.rom_data;
                state_d = IMM;
            end
            IMM, WAIT: begin
                if (bus.done) begin
                    pc_d    = pc + ADDR_W'(1);
                    state_d = RD;
                end else if (wdog_expire) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end
            default: state_d = IDLE;
        endcase

        din_d = '0;
        unique case (state_d)
            ISSUE_A, ISSUE_B, IMM_RD, WAIT: din_d = instr_d;
            IMM:                            din_d = imm_d;
            default:                        din_d = '0;
        endcase
        run_d    = (state_d == ISSUE_B);
        busy_d   = (state_d != IDLE) && (state_d != HALT);
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc      <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            err     <= 1'b0;
            din_q   <= '0;
            run_q   <= 1'b0;
            busy    <= 1'b0;
            halted  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            err     <= err_d;
            din_q   <= din_d;
            run_q   <= run_d;
            busy    <= busy_d;
            halted  <= halted_d;
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed self-checking bench for instr_feeder; the ROM model answers rom_addr directly.
module tb_instr_feeder;
    import feeder_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  pc;
    logic        busy, halted, err;
    logic [8:0]  rom [32];
    int          checks   = 0;
    int          failures = 0;

    instr_feeder_if bus();

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    instr_feeder dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus),
        .pc     (pc),
        .busy   (busy),
        .halted (halted),
        .err    (err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom(input logic [8:0] w);
        for (int i = 0; i < 32; i++) rom[i] = w;
    endtask

    initial begin
        int         last_run;
        int         pulses;
        int         no_run;
        logic [8:0] prev_din;
        logic [8:0] run_din [2];
        logic       seen;

        rst      = 1'b1;
        start    = 1'b0;
        bus.done = 1'b0;
        fill_rom(9'h1C0);
        repeat (2) cyc();

        // reset state
        chk("rst_busy",   32'(busy),    32'd0);
        chk("rst_halted", 32'(halted),  32'd0);
        chk("rst_err",    32'(err),     32'd0);
        chk("rst_pc",     32'(pc),      32'd0);
        chk("rst_run",    32'(bus.run), 32'd0);
        chk("rst_din",    32'(bus.din), 32'd0);
        rst = 1'b0;
        cyc();

        // mv R1,R2 then HALT
        rom[0] = 9'b000_001_010;
        rom[1] = 9'b111_000_000;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("mv_rd_busy", 32'(busy), 32'd1);
        chk("mv_rd_din",  32'(bus.din), 32'd0);
        cyc();
        chk("mv_a_din", 32'(bus.din), 32'h00A);
        chk("mv_a_run", 32'(bus.run), 32'd0);
        cyc();
        chk("mv_b_din", 32'(bus.din), 32'h00A);
        chk("mv_b_run", 32'(bus.run), 32'd1);
        cyc();
        chk("mv_wait_run", 32'(bus.run), 32'd0);
        cyc();
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        chk("mv_pc_inc", 32'(pc), 32'd1);
        cyc();
        cyc();
        chk("mv_halted", 32'(halted),  32'd1);
        chk("mv_pc_end", 32'(pc),      32'd1);
        chk("mv_busy",   32'(busy),    32'd0);
        chk("mv_hdin",   32'(bus.din), 32'd0);
        chk("mv_err",    32'(err),     32'd0);

        // mvi R3,#0x5A then HALT
        rom[0] = 9'b001_011_000;
        rom[1] = 9'h05A;
        rom[2] = 9'b111_000_000;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("mvi_a_din", 32'(bus.din), 32'h058);
        cyc();
        chk("mvi_b_run", 32'(bus.run), 32'd1);
        chk("mvi_b_din", 32'(bus.din), 32'h058);
        cyc();
        chk("mvi_rd_din", 32'(bus.din), 32'h058);
        chk("mvi_rd_pc",  32'(pc),      32'd1);
        chk("mvi_rd_run", 32'(bus.run), 32'd0);
        cyc();
        chk("mvi_imm_din0", 32'(bus.din), 32'h05A);
        cyc();
        chk("mvi_imm_din1", 32'(bus.din), 32'h05A);
        chk("mvi_imm_run",  32'(bus.run), 32'd0);
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        cyc();
        cyc();
        chk("mvi_halted", 32'(halted), 32'd1);
        chk("mvi_pc_end", 32'(pc),     32'd2);

        // add then sub, done 4 cycles after each run
        rom[0] = 9'b010_000_001;
        rom[1] = 9'b011_000_001;
        rom[2] = 9'b111_000_000;
        last_run = -100;
        pulses   = 0;
        prev_din = bus.din;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k < 80 && !halted; k++) begin
            bus.done = (k == last_run + 4);
            if (bus.run) begin
                chk("addsub_din_stable", 32'(bus.din), 32'(prev_din));
                if (pulses < 2) run_din[pulses] = bus.din;
                pulses++;
                last_run = k;
            end
            prev_din = bus.din;
            cyc();
        end
        bus.done = 1'b0;
        chk("addsub_pulses", 32'(pulses),     32'd2);
        chk("addsub_din0",   32'(run_din[0]), 32'h081);
        chk("addsub_din1",   32'(run_din[1]), 32'h0C1);
        chk("addsub_halted", 32'(halted),     32'd1);
        chk("addsub_err",    32'(err),        32'd0);

        // illegal opcode
        rom[0] = 9'b100_000_000;
        no_run = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 0; k < 20 && !halted; k++) begin
            if (bus.run) no_run++;
            cyc();
        end
        chk("ill_runs",   32'(no_run), 32'd0);
        chk("ill_err",    32'(err),    32'd1);
        chk("ill_halted", 32'(halted), 32'd1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("ill_restart_err",  32'(err),  32'd0);
        chk("ill_restart_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 20 && !halted; k++) cyc();
        chk("ill_rehalt", 32'(halted), 32'd1);

        // reset during WAIT of an add at pc=1
        rom[0] = 9'b000_001_010;
        rom[1] = 9'b010_000_001;
        rom[2] = 9'b111_000_000;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        repeat (3) cyc();
        chk("rstw_pc",   32'(pc),      32'd1);
        chk("rstw_busy", 32'(busy),    32'd1);
        chk("rstw_din",  32'(bus.din), 32'h081);
        rst = 1'b1;
        cyc();
        chk("rstw_pc0",   32'(pc),      32'd0);
        chk("rstw_run0",  32'(bus.run), 32'd0);
        chk("rstw_din0",  32'(bus.din), 32'd0);
        chk("rstw_idle",  32'(busy),    32'd0);
        chk("rstw_nhalt", 32'(halted),  32'd0);
        rst = 1'b0;
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        cyc();
        chk("rstw_done_ign_busy", 32'(busy), 32'd0);
        chk("rstw_done_ign_pc",   32'(pc),   32'd0);

        // done withheld in WAIT
        rom[0] = 9'b010_000_001;
        rom[1] = 9'b111_000_000;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
`ifdef FEEDER_WATCHDOG_EN
        repeat (15) cyc();
        chk("wdog_pre_halted", 32'(halted), 32'd0);
        chk("wdog_pre_busy",   32'(busy),   32'd1);
        cyc();
        chk("wdog_halted", 32'(halted), 32'd1);
        chk("wdog_err",    32'(err),    32'd1);
`else
        repeat (100) cyc();
        chk("nowdog_busy",   32'(busy),    32'd1);
        chk("nowdog_halted", 32'(halted),  32'd0);
        chk("nowdog_err",    32'(err),     32'd0);
        chk("nowdog_din",    32'(bus.din), 32'h081);
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        repeat (2) cyc();
        chk("nowdog_exit_halted", 32'(halted), 32'd1);
`endif

        // mvi at address 31 takes its immediate from address 0
        fill_rom(9'b000_001_010);
        rom[0]  = 9'h033;
        rom[31] = 9'b001_011_000;
        last_run = -100;
        seen     = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k < 400 && !seen; k++) begin
            bus.done = (k == last_run + 2);
            if (bus.run) begin
                last_run = k;
                if (bus.din == 9'h058) seen = 1'b1;
            end
            if (!seen) cyc();
        end
        bus.done = 1'b0;
        chk("wrap_seen",  32'(seen), 32'd1);
        chk("wrap_pc31",  32'(pc),   32'd31);
        cyc();
        chk("wrap_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("wrap_pc0",      32'(pc),           32'd0);
        cyc();
        chk("wrap_imm_din", 32'(bus.din), 32'h033);
        chk("wrap_imm_run", 32'(bus.run), 32'd0);
        bus.done = 1'b1;
        cyc();
        bus.done = 1'b0;
        chk("wrap_pc1", 32'(pc), 32'd1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
